depacketizer_2: RTL and testbench

DEPACKETIZER_2 -- requirements
Module: depacketizer_2

---
 rtl/depacketizer_2_if.sv | 28 ++
 rtl/depacketizer_2.sv | 113 +++++++++++
 tb/tb_depacketizer_2.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/depacketizer_2_if.sv
// Flit-input / packet-output bundle of depacketizer_2.
// The slave modport is the depacketizer side; master is the NoC/sink side.
interface depacketizer_2_if #(
  parameter int unsigned ADDRESS_WIDTH    = 4,
  parameter int unsigned VC_ADDRESS_WIDTH = 1,
  parameter int unsigned WIDTH_IN         = 36,
  parameter int unsigned WIDTH_OUT        = 56
);
  logic [WIDTH_IN-1:0]         data_in;
  logic                        valid_in;
  logic                        ready_out;
  logic [WIDTH_OUT-1:0]        data_out;
  logic [ADDRESS_WIDTH-1:0]    dst_out;
  logic [VC_ADDRESS_WIDTH-1:0] vc_out;
  logic                        valid_out;
  logic                        ready_in;
  logic                        error_out;

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, dst_out, vc_out, valid_out, error_out
  );

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, dst_out, vc_out, valid_out, error_out
  );
endinterface

// File: rtl/depacketizer_2.sv
// Reassembles a head flit plus an optional tail body flit into one wide word
// with destination and VC sideband; malformed flit sequences pulse error_out.
module depacketizer_2 #(
  parameter int unsigned ADDRESS_WIDTH    = 4,
  parameter int unsigned VC_ADDRESS_WIDTH = 1,
  parameter int unsigned WIDTH_IN         = 36,
  parameter int unsigned WIDTH_OUT        = 56
) (
  input  logic            clk,
  input  logic            rst,
  depacketizer_2_if.slave bus
);
  localparam int unsigned HEAD_W = WIDTH_IN - 3 - ADDRESS_WIDTH - VC_ADDRESS_WIDTH;
  localparam int unsigned BODY_W = WIDTH_IN - 3 - VC_ADDRESS_WIDTH;
  localparam int unsigned CAT_W  = HEAD_W + BODY_W;
  localparam int unsigned DROP_W = CAT_W - WIDTH_OUT;

  typedef enum logic {IDLE, BODY} state_t;

  state_t                      state;
  logic [HEAD_W-1:0]           hold_payload;
  logic [ADDRESS_WIDTH-1:0]    hold_dst;
  logic [VC_ADDRESS_WIDTH-1:0] hold_vc;
  logic [WIDTH_OUT-1:0]        data_q;
  logic [ADDRESS_WIDTH-1:0]    dst_q;
  logic [VC_ADDRESS_WIDTH-1:0] vc_q;
  logic                        valid_q;
  logic                        error_q;

  logic                        ready;
  logic                        accept;
  logic                        flit_valid;
  logic                        is_head;
  logic                        is_tail;
  logic [VC_ADDRESS_WIDTH-1:0] f_vc;
  logic [ADDRESS_WIDTH-1:0]    f_dst;
  logic [HEAD_W-1:0]           head_payload;
  logic [BODY_W-1:0]           body_payload;
  logic [WIDTH_OUT-1:0]        single_word;
  logic [WIDTH_OUT-1:0]        joined_word;

  // Flit field decode (head and body views overlap on the same bits)
  assign flit_valid   = bus.data_in[WIDTH_IN-1];
  assign is_head      = bus.data_in[WIDTH_IN-2];
  assign is_tail      = bus.data_in[WIDTH_IN-3];
  assign f_vc         = bus.data_in[WIDTH_IN-4 -: VC_ADDRESS_WIDTH];
  assign f_dst        = bus.data_in[WIDTH_IN-4-VC_ADDRESS_WIDTH -: ADDRESS_WIDTH];
  assign head_payload = bus.data_in[HEAD_W-1:0];
  assign body_payload = bus.data_in[BODY_W-1:0];

  // Head payload MSB-first followed by body payload; keep the top WIDTH_OUT bits
  assign single_word = WIDTH_OUT'({head_payload, {BODY_W{1'b0}}} >> DROP_W);
  assign joined_word = WIDTH_OUT'({hold_payload, body_payload} >> DROP_W);

  assign ready  = !valid_q || bus.ready_in;
  assign accept = bus.valid_in && ready;

  assign bus.ready_out = ready;
  assign bus.data_out  = data_q;
  assign bus.dst_out   = dst_q;
  assign bus.vc_out    = vc_q;
  assign bus.valid_out = valid_q;
  assign bus.error_out = error_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hold_payload <= '0;
      hold_dst     <= '0;
      hold_vc      <= '0;
      data_q       <= '0;
      dst_q        <= '0;
      vc_q         <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      error_q <= 1'b0;
      if (valid_q && bus.ready_in) begin
        valid_q <= 1'b0;
      end
      // A completing packet overrides the clear above, reloading the output
      if (accept && flit_valid) begin
        if (is_head) begin
          if (state == BODY) begin
            error_q <= 1'b1;
          end
          if (is_tail) begin
            data_q  <= single_word;
            dst_q   <= f_dst;
            vc_q    <= f_vc;
            valid_q <= 1'b1;
            state   <= IDLE;
          end else begin
            hold_payload <= head_payload;
            hold_dst     <= f_dst;
            hold_vc      <= f_vc;
            state        <= BODY;
          end
        end else if (state == IDLE) begin
          error_q <= 1'b1;
        end else if (is_tail) begin
          data_q  <= joined_word;
          dst_q   <= hold_dst;
          vc_q    <= hold_vc;
          valid_q <= 1'b1;
          state   <= IDLE;
        end else begin
          error_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_depacketizer_2.sv
// Directed self-checking bench for depacketizer_2 with hand-computed expectations.
module tb_depacketizer_2;
  localparam int unsigned AW = 4;
  localparam int unsigned VW = 1;
  localparam int unsigned WI = 36;
  localparam int unsigned WO = 56;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  depacketizer_2_if #(
    .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW), .WIDTH_IN(WI), .WIDTH_OUT(WO)
  ) bus ();

  depacketizer_2 #(
    .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW), .WIDTH_IN(WI), .WIDTH_OUT(WO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WI-1:0] head_flit(input logic tail, input logic vc,
                                              input logic [3:0] dst, input logic [27:0] pay);
    return {1'b1, 1'b1, tail, vc, dst, pay};
  endfunction

  function automatic logic [WI-1:0] body_flit(input logic tail, input logic [31:0] pay);
    return {1'b1, 1'b0, tail, 1'b0, pay};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one flit for a single cycle (caller guarantees ready_out=1)
  task automatic send(input logic [WI-1:0] f);
    bus.data_in  = f;
    bus.valid_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [55:0] d,
                           input logic [3:0] dst, input logic vc);
    check({tag, ".valid"}, 64'(bus.valid_out), 64'(v));
    check({tag, ".data"},  64'(bus.data_out),  64'(d));
    check({tag, ".dst"},   64'(bus.dst_out),   64'(dst));
    check({tag, ".vc"},    64'(bus.vc_out),    64'(vc));
  endtask

  initial begin
    logic [27:0] b2b_pay [4];
    n_cmp = 0;
    n_err = 0;
    rst          = 1'b1;
    bus.data_in  = '0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    b2b_pay[0] = 28'h1000001;
    b2b_pay[1] = 28'h2000002;
    b2b_pay[2] = 28'h3000003;
    b2b_pay[3] = 28'h4000004;

    // Reset state
    step();
    step();
    check_out("rst", 1'b0, 56'h0, 4'h0, 1'b0);
    check("rst.error", 64'(bus.error_out), 64'd0);
    check("rst.ready", 64'(bus.ready_out), 64'd1);
    rst = 1'b0;
    step();
    check("post_rst.ready", 64'(bus.ready_out), 64'd1);

    // Single head+tail flit
    send(head_flit(1'b1, 1'b1, 4'hA, 28'hBCDEF12));
    check_out("single", 1'b1, 56'hBCDEF12_0000000, 4'hA, 1'b1);
    check("single.error", 64'(bus.error_out), 64'd0);
    step();
    check("single.clear", 64'(bus.valid_out), 64'd0);

    // Head then tail body
    send(head_flit(1'b0, 1'b0, 4'h3, 28'h1234567));
    check("two.head_valid", 64'(bus.valid_out), 64'd0);
    check("two.head_err", 64'(bus.error_out), 64'd0);
    send(body_flit(1'b1, 32'h89ABCDE0));
    check_out("two", 1'b1, 56'h1234567_89ABCDE, 4'h3, 1'b0);
    check("two.error", 64'(bus.error_out), 64'd0);
    step();
    check("two.clear", 64'(bus.valid_out), 64'd0);

    // Backpressure: output held, next flit stalled, then reload on release
    bus.ready_in = 1'b0;
    send(head_flit(1'b1, 1'b0, 4'h5, 28'h0ABCDEF));
    bus.data_in  = head_flit(1'b1, 1'b1, 4'h6, 28'h7654321);
    bus.valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp.ready", 64'(bus.ready_out), 64'd0);
      check_out("bp.hold", 1'b1, 56'h0ABCDEF_0000000, 4'h5, 1'b0);
      step();
    end
    bus.ready_in = 1'b1;
    #1;
    check("bp.release_ready", 64'(bus.ready_out), 64'd1);
    step();
    bus.valid_in = 1'b0;
    check_out("bp.reload", 1'b1, 56'h7654321_0000000, 4'h6, 1'b1);
    step();
    check("bp.drain_valid", 64'(bus.valid_out), 64'd0);
    check("bp.drain_ready", 64'(bus.ready_out), 64'd1);

    // Body flit while idle
    send(body_flit(1'b1, 32'hDEADBEEF));
    check("idle_body.error", 64'(bus.error_out), 64'd1);
    check("idle_body.valid", 64'(bus.valid_out), 64'd0);
    step();
    check("idle_body.pulse", 64'(bus.error_out), 64'd0);

    // Head, head, tail: second head replaces the first
    send(head_flit(1'b0, 1'b0, 4'h1, 28'h1111111));
    check("hht.first_err", 64'(bus.error_out), 64'd0);
    send(head_flit(1'b0, 1'b1, 4'h2, 28'h2222222));
    check("hht.second_err", 64'(bus.error_out), 64'd1);
    send(body_flit(1'b1, 32'h33333330));
    check("hht.tail_err", 64'(bus.error_out), 64'd0);
    check_out("hht", 1'b1, 56'h2222222_3333333, 4'h2, 1'b1);
    step();

    // Third (non-tail body) flit is dropped, packet still completes
    send(head_flit(1'b0, 1'b0, 4'h4, 28'hAAAAAAA));
    send(body_flit(1'b0, 32'hFFFFFFFF));
    check("third.error", 64'(bus.error_out), 64'd1);
    check("third.valid", 64'(bus.valid_out), 64'd0);
    send(body_flit(1'b1, 32'h5555555F));
    check("third.tail_err", 64'(bus.error_out), 64'd0);
    check_out("third", 1'b1, 56'hAAAAAAA_5555555, 4'h4, 1'b0);

    // Asynchronous reset in the middle of a packet
    send(head_flit(1'b0, 1'b1, 4'h7, 28'h0F0F0F0));
    #2;
    rst = 1'b1;
    #1;
    check_out("arst", 1'b0, 56'h0, 4'h0, 1'b0);
    step();
    rst = 1'b0;
    send(body_flit(1'b1, 32'h12345670));
    check("arst.tail_err", 64'(bus.error_out), 64'd1);
    check("arst.tail_valid", 64'(bus.valid_out), 64'd0);

    // All-zero flit is consumed with no effect, even mid-packet
    send('0);
    check("zero.error", 64'(bus.error_out), 64'd0);
    check("zero.valid", 64'(bus.valid_out), 64'd0);
    send(head_flit(1'b0, 1'b0, 4'h9, 28'hCAFE123));
    send('0);
    check("zero_mid.error", 64'(bus.error_out), 64'd0);
    send(body_flit(1'b1, 32'h456789A0));
    check_out("zero_mid", 1'b1, 56'hCAFE123_456789A, 4'h9, 1'b0);
    step();

    // Back-to-back single-flit packets
    bus.valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.data_in = head_flit(1'b1, i[0], 4'(i + 8), b2b_pay[i]);
      step();
      check("b2b.ready", 64'(bus.ready_out), 64'd1);
      check_out("b2b", 1'b1, {b2b_pay[i], 28'h0}, 4'(i + 8), i[0]);
    end
    bus.valid_in = 1'b0;
    step();
    check("b2b.end", 64'(bus.valid_out), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
